// File: rtl/mgc_in_fifo_wait_buf_pkg.sv
// Shared definitions for the input-side wait FIFO: handshake polarity and the
// width helpers used to size counters and pointers at elaboration.
package mgc_in_fifo_wait_buf_pkg;

    localparam logic MGC_HS_ACTIVE = 1'b1;
    localparam logic MGC_HS_IDLE   = 1'b0;

    function automatic int mgc_clog2(input int v);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Pointer width: at least one bit even for a single-entry buffer.
    function automatic int mgc_ptr_w(input int depth);
        return (depth > 1) ? mgc_clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mgc_in_fifo_wait_buf_mem.sv
// Storage array for the input wait FIFO: one write port, one asynchronous read
// port, cleared by the asynchronous reset.
module mgc_in_fifo_wait_mem
    import mgc_in_fifo_wait_buf_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 8,
    parameter int aw    = mgc_ptr_w(depth)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             we,
    input  logic [aw-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [aw-1:0]    raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] r_mem [depth];

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            for (int i = 0; i < depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/mgc_in_fifo_wait_buf.sv
// Input-side wait FIFO: producer valid/accept on (vz, z, lz), core request/valid
// on (ld, vd, d), first-word fall-through, optional pass-through at depth 0.
module mgc_in_fifo_wait_buf
    import mgc_in_fifo_wait_buf_pkg::*;
#(
    parameter int   rscid   = 0,
    parameter int   width   = 8,
    parameter int   fifo_sz = 8,
    parameter logic ph_en   = 1'b1,
    parameter int   ph_log2 = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic             ld,
    output logic             vd,
    output logic [width-1:0] d,
    output logic             lz,
    input  logic             vz,
    input  logic [width-1:0] z,
    output logic [31:0]      size
);

    generate
        if (fifo_sz == 0) begin : g_pass
            assign vd   = vz;
            assign d    = z;
            assign lz   = ld;
            assign size = '0;

            logic w_unused;
            assign w_unused = &{1'b0, clk, arst, en};
        end else begin : g_buf
            if (ph_log2 != mgc_clog2(fifo_sz + 1)) begin : g_bad_cfg
                $error("mgc_in_fifo_wait_buf: ph_log2 must equal clog2(fifo_sz+1)");
            end

            localparam int                 AW       = mgc_ptr_w(fifo_sz);
            localparam logic [AW-1:0]      LAST_PTR = AW'(fifo_sz - 1);
            localparam logic [AW-1:0]      PTR_ONE  = AW'(1);
            localparam logic [ph_log2-1:0] FULL_CNT = ph_log2'(fifo_sz);
            localparam logic [ph_log2-1:0] CNT_ONE  = ph_log2'(1);

            logic [AW-1:0]      r_wr_ptr;
            logic [AW-1:0]      r_rd_ptr;
            logic [ph_log2-1:0] r_count;
            logic               w_en_act;
            logic               w_lz;
            logic               w_vd;
            logic               w_push;
            logic               w_pop;

            // Handshake flags come only from registered count and en, so a
            // same-cycle pop never frees room for a push when full.
            assign w_en_act = (en == ph_en);
            assign w_lz     = w_en_act & (r_count != FULL_CNT);
            assign w_vd     = w_en_act & (r_count != '0);
            assign w_push   = w_lz & (vz == MGC_HS_ACTIVE);
            assign w_pop    = w_vd & (ld == MGC_HS_ACTIVE);

            always_ff @(posedge clk or negedge arst) begin
                if (!arst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_ONE;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_ONE;
                    end
                    if (w_push && !w_pop) begin
                        r_count <= r_count + CNT_ONE;
                    end else if (w_pop && !w_push) begin
                        r_count <= r_count - CNT_ONE;
                    end
                end
            end

            mgc_in_fifo_wait_mem #(
                .width (width),
                .depth (fifo_sz),
                .aw    (AW)
            ) u_mem (
                .clk   (clk),
                .arst  (arst),
                .we    (w_push),
                .waddr (r_wr_ptr),
                .wdata (z),
                .raddr (r_rd_ptr),
                .rdata (d)
            );

            assign lz   = w_lz;
            assign vd   = w_vd;
            assign size = 32'(r_count);
        end
    endgenerate

endmodule
